rca_wb_control: RTL
===================

// Module: rca_wb_control
// PURPOSE
//  Writeback-side counterpart of the RCA issue control. Buffers results leaving the RCA grid
//  (non-feedback and feedback streams) and pairs the oldest result with the ID at the head
//  of the RCA ID FIFO. Presents the pair to the Taiga writeback unit, then pulses
//  wb_committing so issue control pops that ID. Sits between the grid output stage and writeback.
// PARAMETERS
//  XLEN              32  result data width
//  ID_W              3   width of id_t
//  RESULT_FIFO_DEPTH 4   entries per result stream FIFO (power of 2, >=2)
// PORTS
//  clk            in   1     clock
//  rst_n          in   1     reset
//  wb_id          in   ID_W  ID at head of issue-side ID FIFO
//  wb_fb_instr    in   1     head ID is a feedback instruction
//  fifo_populated in   1     issue-side ID FIFO non-empty
//  clear_fifos    in   1     switching accelerator: flush result FIFOs
//  res_valid      in   1     non-feedback grid result valid (one-cycle strobe, no backpressure)
//  res_data       in   XLEN  non-feedback result
//  fb_res_valid   in   1     feedback grid result valid (one-cycle strobe)
//  fb_res_data    in   XLEN  feedback result
//  wb_done        out  1     result presented to writeback
//  wb_rd          out  XLEN  presented result
//  wb_id_out      out  ID_W  ID of presented result
//  wb_ack         in   1     writeback accepts presented result
//  wb_committing  out  1     head ID retired this cycle (to issue-side ID FIFO pop)
//  overflow_err   out  1     sticky: a result strobe hit a full FIFO
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low. All outputs 0; both FIFOs empty;
//    state IDLE.
//  - Result FIFOs: one per stream. Push on *_valid at the clock edge; data visible at the head
//    in the next cycle. Push when full drops the data and sets overflow_err (cleared only by reset).
//  - Stream select: sel = wb_fb_instr ? feedback FIFO : non-feedback FIFO. The other FIFO is
//    never popped for the current ID.
//  - FSM:
//    IDLE    -> PRESENT when fifo_populated && sel FIFO non-empty && !clear_fifos.
//               On the transition edge, load wb_rd <= sel head and wb_id_out <= wb_id.
//    PRESENT -> wb_done=1; wb_rd and wb_id_out held stable until ack.
//               On wb_ack: wb_committing = wb_done & wb_ack (combinational, same cycle),
//               pop sel FIFO on that edge, then return to IDLE.
//  - The mandatory IDLE bubble after each commit lets the ID FIFO head update. Sustained
//    throughput is 1 result per 2 cycles while ack is immediate.
//  - Latency: res_valid at edge N -> head visible cycle N+1 -> wb_done=1 in cycle N+2
//    (head ID already populated). Back-to-back acks: next wb_done 2 cycles after the prior ack.
//  - wb_committing is never asserted outside PRESENT; at most 1 pulse per presented result.
//  - clear_fifos: empties both result FIFOs on the edge (overflow_err unaffected).
//    Push and clear in the same cycle: clear wins, the strobe is dropped without error.
//    In IDLE, clear also blocks the load that cycle.
//    clear in PRESENT is a protocol violation (issue side clears only when the ID FIFO is
//    empty). Flag it with an assertion; the held wb_rd/wb_id_out and wb_done stay intact
//    until ack.
//  - Pop and push on the same FIFO in the same cycle are both honoured; count is unchanged,
//    also when full.
//  - FIFO pointers wrap modulo RESULT_FIFO_DEPTH; count width is $clog2(DEPTH)+1.
//  - wb_ack outside PRESENT is ignored.
//  - Reset mid-PRESENT: wb_done drops asynchronously, and nothing commits.
// TESTING
//  1 Single non-fb: populated=1, fb=0, id=3, res_valid data=0xDEAD_BEEF at edge N
//    -> done in cycle N+2, rd=0xDEADBEEF, id_out=3; ack -> wb_committing=1 in that cycle only.
//  2 Feedback routing: fb=1, only res_valid (0x11) arrives -> no done. fb_res 0x22 arrives
//    -> done with rd=0x22, and 0x11 is still queued.
//  3 Backpressure: hold ack=0 for 10 cycles -> done, rd and id_out stable with no commit.
//    ack -> one commit pulse, IDLE next cycle.
//  4 Overflow: 5 res_valid strobes with no ack (DEPTH=4) -> overflow_err=1 after the 5th.
//    First 4 values drain in order on acks.
//  5 clear_fifos in IDLE with 2 queued and a same-cycle res_valid -> FIFO empty, no done,
//    overflow_err unchanged.
//  6 Async reset: drop rst_n mid-PRESENT, off the clock edge -> wb_done=0 immediately;
//    after release, FIFOs empty, no commit pulse.

Source files
------------

// File: rtl/rca_wb_control.sv
// RCA writeback control: buffers grid results per stream and hands the oldest result for the
// head issue ID to the writeback unit, retiring that ID when writeback acknowledges it.

module rca_wb_result_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          do_pop;
    logic          do_push;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign head     = mem[rd_ptr];
    // Clear wins over everything; a full FIFO still accepts a push when it is popped too.
    assign do_pop   = pop && !empty && !clear;
    assign do_push  = push && !clear && (!full || do_pop);
    assign overflow = push && !clear && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module rca_wb_control #(
    parameter int XLEN              = 32,
    parameter int ID_W              = 3,
    parameter int RESULT_FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ID_W-1:0] wb_id,
    input  logic            wb_fb_instr,
    input  logic            fifo_populated,
    input  logic            clear_fifos,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_data,
    input  logic            fb_res_valid,
    input  logic [XLEN-1:0] fb_res_data,
    output logic            wb_done,
    output logic [XLEN-1:0] wb_rd,
    output logic [ID_W-1:0] wb_id_out,
    input  logic            wb_ack,
    output logic            wb_committing,
    output logic            overflow_err
);
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state;
    logic            pres_fb;
    logic [XLEN-1:0] nf_head;
    logic [XLEN-1:0] fb_head;
    logic            nf_empty;
    logic            fb_empty;
    logic            nf_overflow;
    logic            fb_overflow;
    logic            sel_empty;
    logic [XLEN-1:0] sel_head;

    // Handshake: wb_done is valid and wb_ack is ready; a result transfers (and its ID retires)
    // in the cycle both are high, and wb_rd/wb_id_out stay frozen until that cycle.
    assign wb_committing = wb_done & wb_ack;

    assign sel_empty = wb_fb_instr ? fb_empty : nf_empty;
    assign sel_head  = wb_fb_instr ? fb_head  : nf_head;

    rca_wb_result_fifo #(
        .W     (XLEN),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_nf_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_fifos),
        .push      (res_valid),
        .push_data (res_data),
        .pop       (wb_committing && !pres_fb),
        .head      (nf_head),
        .empty     (nf_empty),
        .overflow  (nf_overflow)
    );

    rca_wb_result_fifo #(
        .W     (XLEN),
        .DEPTH (RESULT_FIFO_DEPTH)
    ) u_fb_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_fifos),
        .push      (fb_res_valid),
        .push_data (fb_res_data),
        .pop       (wb_committing && pres_fb),
        .head      (fb_head),
        .empty     (fb_empty),
        .overflow  (fb_overflow)
    );

    // The stream is latched at load so the pop always hits the FIFO the result came from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wb_done      <= 1'b0;
            wb_rd        <= '0;
            wb_id_out    <= '0;
            pres_fb      <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (nf_overflow || fb_overflow) begin
                overflow_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fifo_populated && !sel_empty && !clear_fifos) begin
                        state     <= PRESENT;
                        wb_done   <= 1'b1;
                        wb_rd     <= sel_head;
                        wb_id_out <= wb_id;
                        pres_fb   <= wb_fb_instr;
                    end
                end
                PRESENT: begin
                    if (wb_ack) begin
                        state   <= IDLE;
                        wb_done <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    wb_done <= 1'b0;
                end
            endcase
        end
    end

    a_no_clear_in_present: assert property (
        @(posedge clk) disable iff (!rst_n) (state == PRESENT) |-> !clear_fifos
    );

    a_commit_only_in_present: assert property (
        @(posedge clk) disable iff (!rst_n) wb_committing |-> (state == PRESENT)
    );
endmodule
